// File: rtl/fifo_sync.sv
// fifo_sync: synchronous circular-buffer FIFO placed upstream of flow_control.
// Words come out in the order they went in, one cycle after the pop that reads them.
// The status flags are decoded from the registered occupancy count, so push and pop
// have no combinational path to them. A sticky error flag records any overflow or
// underflow. After an error the FIFO keeps operating normally until reset.
module fifo_sync #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int AE_TH      = 1,
  parameter int AF_TH      = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  Fifo_empty,
  output logic                  Fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Sized constants used for pointer and count arithmetic and for the threshold compares.
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = (ADDR_WIDTH)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH + 1)'(0);
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AE_C      = (ADDR_WIDTH + 1)'(AE_TH);
  localparam logic [ADDR_WIDTH:0]   AF_C      = (ADDR_WIDTH + 1)'(AF_TH);

  // Storage array. It is left out of reset on purpose, because only the pointers and
  // the count define which entries are valid.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  valid_r;
  logic                  error_r;

  logic empty_s;
  logic full_s;
  logic pop_ok_s;
  logic push_ok_s;
  logic overflow_s;
  logic underflow_s;

  // Occupancy decodes, which depend only on registered state.
  assign empty_s = (count_r == CNT_ZERO);
  assign full_s  = (count_r == CNT_DEPTH);

  // Acceptance and error qualification for this cycle's requests.
  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  // A pop on an empty FIFO is never accepted: there is no fall-through path.
  assign pop_ok_s    = pop & ~empty_s;
  assign push_ok_s   = push & (~full_s | pop_ok_s);
  assign overflow_s  = push & full_s & ~pop_ok_s;
  assign underflow_s = pop & empty_s;

  // Next-state computation for the pointers and the occupancy count.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (push_ok_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_ok_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      2'b11:   count_nxt_s = count_r;
      2'b00:   count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and count registers. An asserted reset discards all stored words immediately.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Storage write port. Only an accepted push writes, so a dropped word never lands in memory.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Registered read port. When no pop is accepted, data_out keeps its last word
  // and valid_out is cleared.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out_r <= '0;
      valid_r    <= 1'b0;
    end else if (pop_ok_s) begin
      data_out_r <= mem_r[rd_ptr_r];
      valid_r    <= 1'b1;
    end else begin
      data_out_r <= data_out_r;
      valid_r    <= 1'b0;
    end
  end

  // Sticky error flag. Once set, it is cleared only by reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      error_r <= 1'b0;
    end else if (overflow_s || underflow_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign data_out     = data_out_r;
  assign valid_out    = valid_r;
  assign error_out    = error_r;
  assign Fifo_empty   = empty_s;
  assign Fifo_full    = full_s;
  assign almost_empty = (count_r <= AE_C);
  assign almost_full  = (count_r >= AF_C);

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed bench for fifo_sync. Stimulus pushes the hand-computed word
// expected from each accepted pop into a queue. A negedge monitor compares data_out
// against that queue whenever valid_out is high. Status flags are checked directly
// after each step.
module tb_fifo_sync;

  logic       clk;
  logic       reset_L;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       Fifo_empty;
  logic       Fifo_full;
  logic       almost_empty;
  logic       almost_full;
  logic       error_out;

  int         n_checks;
  int         n_fail;
  logic [5:0] exp_q[$];
  logic [5:0] mon_exp;

  fifo_sync #(
    .DATA_WIDTH(6),
    .ADDR_WIDTH(2),
    .AE_TH(1),
    .AF_TH(3)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .push(push),
    .data_in(data_in),
    .pop(pop),
    .data_out(data_out),
    .valid_out(valid_out),
    .Fifo_empty(Fifo_empty),
    .Fifo_full(Fifo_full),
    .almost_empty(almost_empty),
    .almost_full(almost_full),
    .error_out(error_out)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stop the run if it fails to finish within its time budget.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required < 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor. Any valid_out pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_L && valid_out) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_spurious: got valid data 0x%02h, required no valid output", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_out !== mon_exp) begin
          n_fail++;
          $display("FAIL scoreboard_data: got 0x%02h, required 0x%02h", data_out, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, required 0x%02h", name, got, exp);
    end
  endtask

  // Apply one cycle of stimulus. If a pop is expected to be accepted, queue its word first.
  task automatic step(input logic p, input logic [5:0] d, input logic q,
                      input logic ev, input logic [5:0] ed);
    push    = p;
    data_in = d;
    pop     = q;
    if (ev) exp_q.push_back(ed);
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = 6'h00;
  endtask

  task automatic check_flags(input string tag, input logic e, input logic ae,
                             input logic af, input logic f);
    check({tag, "_empty"}, {7'd0, Fifo_empty}, {7'd0, e});
    check({tag, "_aempty"}, {7'd0, almost_empty}, {7'd0, ae});
    check({tag, "_afull"}, {7'd0, almost_full}, {7'd0, af});
    check({tag, "_full"}, {7'd0, Fifo_full}, {7'd0, f});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_L  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    data_in  = 6'h00;

    // 1. Reset state
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_valid", {7'd0, valid_out}, 8'h00);
    check("reset_data", {2'd0, data_out}, 8'h00);
    check("reset_error", {7'd0, error_out}, 8'h00);
    reset_L = 1'b1;
    @(posedge clk);
    #1;

    // 2. Fill
    step(1'b1, 6'h01, 1'b0, 1'b0, 6'h00);
    check_flags("fill1", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6'h02, 1'b0, 1'b0, 6'h00);
    check_flags("fill2", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 6'h03, 1'b0, 1'b0, 6'h00);
    check_flags("fill3", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 6'h04, 1'b0, 1'b0, 6'h00);
    check_flags("fill4", 1'b0, 1'b0, 1'b1, 1'b1);
    check("fill_error", {7'd0, error_out}, 8'h00);

    // 3. Overflow
    step(1'b1, 6'h3F, 1'b0, 1'b0, 6'h00);
    check("ovf_error", {7'd0, error_out}, 8'h01);
    check_flags("ovf", 1'b0, 1'b0, 1'b1, 1'b1);

    // 4. Drain
    step(1'b0, 6'h00, 1'b1, 1'b1, 6'h01);
    check("drain1_valid", {7'd0, valid_out}, 8'h01);
    check_flags("drain1", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 6'h00, 1'b1, 1'b1, 6'h02);
    step(1'b0, 6'h00, 1'b1, 1'b1, 6'h03);
    check_flags("drain3", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h00, 1'b1, 1'b1, 6'h04);
    check_flags("drain4", 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h00, 1'b0, 1'b0, 6'h00);
    check("idle_valid", {7'd0, valid_out}, 8'h00);
    check("idle_hold", {2'd0, data_out}, 8'h04);

    // 5a. Simultaneous push and pop with count = 2
    step(1'b1, 6'h10, 1'b0, 1'b0, 6'h00);
    step(1'b1, 6'h11, 1'b0, 1'b0, 6'h00);
    step(1'b1, 6'h2A, 1'b1, 1'b1, 6'h10);
    check_flags("sim2", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'h00, 1'b1, 1'b1, 6'h11);
    step(1'b0, 6'h00, 1'b1, 1'b1, 6'h2A);
    check_flags("sim2_drain", 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h00, 1'b0, 1'b0, 6'h00);

    // 5b. Reset to clear the error, then push and pop together on an empty FIFO
    reset_L = 1'b0;
    @(posedge clk);
    #1;
    check("pulse_error", {7'd0, error_out}, 8'h00);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 6'h15, 1'b1, 1'b0, 6'h00);
    check("sim0_valid", {7'd0, valid_out}, 8'h00);
    check("sim0_error", {7'd0, error_out}, 8'h01);
    check_flags("sim0", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h00, 1'b1, 1'b1, 6'h15);
    check_flags("sim0_drain", 1'b1, 1'b1, 1'b0, 1'b0);

    // 6a. Ten push/pop pairs so both pointers wrap
    step(1'b1, 6'h20, 1'b0, 1'b0, 6'h00);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 6'(6'h20 + i), 1'b1, 1'b1, 6'(6'h20 + i - 1));
    end
    step(1'b0, 6'h00, 1'b1, 1'b1, 6'h29);
    check_flags("wrap", 1'b1, 1'b1, 1'b0, 1'b0);

    // 6b. Asynchronous reset with count = 3
    step(1'b1, 6'h30, 1'b0, 1'b0, 6'h00);
    step(1'b1, 6'h31, 1'b0, 1'b0, 6'h00);
    step(1'b1, 6'h32, 1'b0, 1'b0, 6'h00);
    check_flags("pre_rst", 1'b0, 1'b0, 1'b1, 1'b0);
    reset_L = 1'b0;
    #1;
    check_flags("async_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    check("async_rst_error", {7'd0, error_out}, 8'h00);
    check("async_rst_valid", {7'd0, valid_out}, 8'h00);
    check("async_rst_data", {2'd0, data_out}, 8'h00);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    step(1'b0, 6'h00, 1'b0, 1'b0, 6'h00);
    step(1'b0, 6'h00, 1'b0, 1'b0, 6'h00);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
